// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the mc_cpu_core multi-cycle processor:
// opcodes, FSM states, and the ALU output bundle.
package mc_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Widest datapath the ALU bundle can carry; narrower cores zero-extend.
    localparam int ALU_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        HALT = 2'd3
    } state_t;

    typedef struct packed {
        logic [ALU_MAX_W-1:0] result;
        logic                 carry;
    } alu_out_t;

    function automatic logic op_is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    endfunction

endpackage

// File: rtl/mc_cpu_core_alu.sv
// Combinational ALU for mc_cpu_core: result and carry for every opcode,
// zero-extended into the shared alu_out_t bundle.
module mc_alu
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output alu_out_t          res
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    // The extra MSB of the difference is the borrow, set exactly when a < b.
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Opcode decode into result and carry.
    always_comb begin
        res = '0;
        case (op)
            OP_ADD: begin
                res.result = ALU_MAX_W'(sum_s[DATA_W-1:0]);
                res.carry  = sum_s[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                res.result = ALU_MAX_W'(diff_s[DATA_W-1:0]);
                res.carry  = diff_s[DATA_W];
            end
            OP_AND: res.result = ALU_MAX_W'(a & b);
            OP_OR:  res.result = ALU_MAX_W'(a | b);
            OP_XOR: res.result = ALU_MAX_W'(a ^ b);
            OP_NOT: res.result = ALU_MAX_W'(~b);
            OP_SHL: begin
                res.result = ALU_MAX_W'({a[DATA_W-2:0], 1'b0});
                res.carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                res.result = ALU_MAX_W'({1'b0, a[DATA_W-1:1]});
                res.carry  = a[0];
            end
            OP_MOV: res.result = ALU_MAX_W'(b);
            OP_LDI: res.result = ALU_MAX_W'(imm);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle processor core: IDLE -> EXEC -> WB sequence per instruction,
// inline register file, flags, illegal-opcode pulse, sticky HALT.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  NREGS   = 4,
    parameter int  CNT_W   = 16,
    localparam int AW      = $clog2(NREGS),
    localparam int INSTR_W = 4 + 2 * AW + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               illegal,
    output logic               halted,
    output logic [CNT_W-1:0]   retired_count
);

    state_t             state_r;
    state_t             state_next_s;
    logic [INSTR_W-1:0] ir_r;
    logic [3:0]         op_s;
    logic [AW-1:0]      rd_s;
    logic [AW-1:0]      rs_s;
    logic [DATA_W-1:0]  imm_s;
    logic [DATA_W-1:0]  regs_r [NREGS];
    logic [DATA_W-1:0]  rd_val_s;
    logic [DATA_W-1:0]  rs_val_s;
    alu_out_t           alu_s;
    alu_out_t           ex_r;
    logic               accept_s;
    logic               wb_alu_s;
    logic               wb_write_s;
    logic               wb_retire_s;
    logic               wb_illegal_s;
    logic               wb_halt_s;

    assign op_s     = ir_r[INSTR_W-1 -: 4];
    assign rd_s     = ir_r[DATA_W+AW +: AW];
    assign rs_s     = ir_r[DATA_W +: AW];
    assign imm_s    = ir_r[DATA_W-1:0];
    assign rd_val_s = regs_r[rd_s];
    assign rs_val_s = regs_r[rs_s];
    assign accept_s = instr_valid && instr_ready && (state_r == IDLE);

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op  (op_s),
        .a   (rd_val_s),
        .b   (rs_val_s),
        .imm (imm_s),
        .res (alu_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = EXEC;
                else          state_next_s = IDLE;
            end
            EXEC: state_next_s = WB;
            WB: begin
                if (op_s == OP_HALT) state_next_s = HALT;
                else                 state_next_s = IDLE;
            end
            HALT:    state_next_s = HALT;
            default: state_next_s = IDLE;
        endcase
    end

    // Write-back decode: what retiring the instruction in IR does.
    always_comb begin
        wb_alu_s     = 1'b0;
        wb_write_s   = 1'b0;
        wb_retire_s  = 1'b0;
        wb_illegal_s = 1'b0;
        wb_halt_s    = 1'b0;
        if (state_r == WB) begin
            wb_alu_s     = op_is_alu(op_s);
            wb_write_s   = op_is_alu(op_s) && (op_s != OP_CMP);
            wb_retire_s  = op_is_alu(op_s) || (op_s == OP_NOP) || (op_s == OP_HALT);
            wb_illegal_s = op_is_illegal(op_s);
            wb_halt_s    = (op_s == OP_HALT);
        end else begin
            wb_alu_s     = 1'b0;
            wb_write_s   = 1'b0;
            wb_retire_s  = 1'b0;
            wb_illegal_s = 1'b0;
            wb_halt_s    = 1'b0;
        end
    end

    // Instruction latch on accept, ALU result capture in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r <= '0;
            ex_r <= '0;
        end else begin
            if (accept_s) ir_r <= instr;
            if (state_r == EXEC) ex_r <= alu_s;
        end
    end

    // Register file: single synchronous write port, used only in WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
        end else if (wb_write_s) begin
            regs_r[rd_s] <= ex_r.result[DATA_W-1:0];
        end
    end

    // Registered outputs; instr_ready follows the state about to be entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_ready   <= 1'b0;
            result        <= '0;
            result_valid  <= 1'b0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            illegal       <= 1'b0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            instr_ready  <= (state_next_s == IDLE);
            result_valid <= wb_alu_s;
            illegal      <= wb_illegal_s;
            if (wb_alu_s) begin
                result     <= ex_r.result[DATA_W-1:0];
                flag_zero  <= (ex_r.result == '0);
                flag_carry <= ex_r.carry;
            end
            if (wb_retire_s) retired_count <= retired_count + CNT_W'(1);
            if (wb_halt_s) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Scoreboard bench for mc_cpu_core: directed and random instructions checked
// against an integer-arithmetic reference model.
module tb_mc_cpu_core;

    localparam int DATA_W  = 8;
    localparam int NREGS   = 4;
    localparam int CNT_W   = 4;
    localparam int AW      = 2;
    localparam int INSTR_W = 4 + 2 * AW + DATA_W;
    localparam int DMOD    = 1 << DATA_W;
    localparam int CMOD    = 1 << CNT_W;

    logic               clk = 1'b0;
    logic               reset;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [DATA_W-1:0]  result;
    logic               result_valid;
    logic               flag_zero;
    logic               flag_carry;
    logic               illegal;
    logic               halted;
    logic [CNT_W-1:0]   retired_count;

    mc_cpu_core #(.DATA_W(DATA_W), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .result        (result),
        .result_valid  (result_valid),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry),
        .illegal       (illegal),
        .halted        (halted),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int ill;
        int res;
        int z;
        int c;
        int cnt;
    } exp_t;
    exp_t q[$];

    int mregs[NREGS];
    int mres, mz, mc, mcnt, mhalt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mregs[i] = 0;
        mres = 0; mz = 0; mc = 0; mcnt = 0; mhalt = 0;
        q.delete();
    endtask

    function automatic void alu_model(input int op, input int a, input int b, input int imm,
                                      output int r, output int c);
        c = 0;
        case (op)
            1:     begin r = a + b; c = (r >= DMOD) ? 1 : 0; r = r % DMOD; end
            2, 11: begin c = (a < b) ? 1 : 0; r = (a - b + DMOD) % DMOD; end
            3:     r = a & b;
            4:     r = a | b;
            5:     r = a ^ b;
            6:     r = (DMOD - 1) - b;
            7:     begin c = (a >= DMOD / 2) ? 1 : 0; r = (a * 2) % DMOD; end
            8:     begin c = a % 2; r = a / 2; end
            9:     r = b;
            10:    r = imm;
            default: r = 0;
        endcase
    endfunction

    // Apply one accepted instruction to the model; queue what the DUT must show.
    task automatic model_accept(input int op, input int rd, input int rs, input int imm,
                                input int due);
        int r, c;
        exp_t e;
        if (op >= 1 && op <= 11) begin
            alu_model(op, mregs[rd], mregs[rs], imm, r, c);
            mres = r; mc = c; mz = (r == 0) ? 1 : 0;
            if (op != 11) mregs[rd] = r;
            mcnt = (mcnt + 1) % CMOD;
            e = '{cyc: due, ill: 0, res: mres, z: mz, c: mc, cnt: mcnt};
            q.push_back(e);
        end else if (op >= 12 && op <= 14) begin
            e = '{cyc: due, ill: 1, res: mres, z: mz, c: mc, cnt: mcnt};
            q.push_back(e);
        end else if (op == 15) begin
            mcnt = (mcnt + 1) % CMOD;
            mhalt = 1;
        end else begin
            mcnt = (mcnt + 1) % CMOD;
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output.
    exp_t me;
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                me = q.pop_front();
                chk("missing_output", 0, 1);
            end
            if (result_valid || illegal) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", int'(result_valid) + 2 * int'(illegal), 0);
                end else begin
                    me = q.pop_front();
                    chk("out_cycle", cyc, me.cyc);
                    chk("illegal", int'(illegal), me.ill);
                    chk("result_valid", int'(result_valid), 1 - me.ill);
                    chk("result", int'(result), me.res);
                    chk("flag_zero", int'(flag_zero), me.z);
                    chk("flag_carry", int'(flag_carry), me.c);
                    chk("retired_count", int'(retired_count), me.cnt);
                end
            end
        end
    end

    // Present one instruction, wait for acceptance, return in EXEC.
    task automatic issue(input int op, input int rd, input int rs, input int imm);
        int n;
        logic [3:0]        op_v;
        logic [AW-1:0]     rd_v, rs_v;
        logic [DATA_W-1:0] imm_v;
        n = 0;
        op_v = op[3:0]; rd_v = rd[AW-1:0]; rs_v = rs[AW-1:0]; imm_v = imm[DATA_W-1:0];
        @(negedge clk);
        instr = {op_v, rd_v, rs_v, imm_v};
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        model_accept(op, rd, rs, imm, cyc + 3);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic issue_wait(input int op, input int rd, input int rs, input int imm);
        issue(op, rd, rs, imm);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr_valid = 1'b0;
        #1;
        model_reset();
        chk("rst_ready", int'(instr_ready), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_zero", int'(flag_zero), 0);
        chk("rst_carry", int'(flag_carry), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_count", int'(retired_count), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("ready_low_at_release", int'(instr_ready), 0);
        @(negedge clk);
        chk("ready_after_release", int'(instr_ready), 1);
    endtask

    initial begin
        int accepts;
        reset = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        model_reset();
        do_reset();

        // Arithmetic and flag rules.
        issue(10, 1, 0, 'hF0);
        issue(10, 2, 0, 'h20);
        issue_wait(1, 1, 2, 0);
        chk("add_result", int'(result), 'h10);
        chk("add_carry", int'(flag_carry), 1);
        chk("add_zero", int'(flag_zero), 0);
        issue_wait(9, 3, 1, 0);
        chk("mov_result", int'(result), 'h10);
        chk("mov_carry", int'(flag_carry), 0);
        issue_wait(2, 0, 0, 0);
        chk("sub_self_zero", int'(flag_zero), 1);
        chk("sub_self_carry", int'(flag_carry), 0);
        issue(10, 1, 0, 'h05);
        issue(10, 2, 0, 'h09);
        issue_wait(11, 1, 2, 0);
        chk("cmp_result", int'(result), 'hFC);
        chk("cmp_borrow", int'(flag_carry), 1);
        issue_wait(9, 0, 1, 0);
        chk("cmp_no_write", int'(result), 'h05);

        // Illegal opcode: one-cycle pulse, nothing else changes.
        issue_wait(12, 1, 2, 'h33);
        chk("illegal_pulse", int'(illegal), 1);
        @(negedge clk);
        chk("illegal_one_cycle", int'(illegal), 0);
        issue_wait(9, 0, 1, 0);

        // Held instr_valid: one accept every third cycle.
        @(negedge clk);
        instr = {4'h1, 2'd1, 2'd2, 8'h00};
        instr_valid = 1'b1;
        accepts = 0;
        for (int j = 0; j < 12; j++) begin
            chk("hs_ready", int'(instr_ready), (j % 3 == 0) ? 1 : 0);
            if (instr_ready) begin
                accepts++;
                model_accept(1, 1, 2, 0, cyc + 3);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("hs_accepts", accepts, 4);

        // Randomized instruction stream (HALT excluded).
        for (int k = 0; k < 60; k++) begin
            issue(int'($urandom_range(0, 14)), int'($urandom_range(0, NREGS - 1)),
                  int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, DMOD - 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // HALT is sticky and blocks further accepts.
        issue_wait(15, 0, 0, 0);
        chk("halted", int'(halted), mhalt);
        chk("halt_count", int'(retired_count), mcnt);
        instr = '0;
        instr_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("halt_ready", int'(instr_ready), 0);
        end
        instr_valid = 1'b0;

        // Reset clears every register.
        do_reset();
        for (int i = 0; i < NREGS; i++) begin
            issue_wait(4, i, i, 0);
            chk("reg_cleared", int'(result), 0);
        end

        // Reset during EXEC aborts the ADD entirely.
        issue_wait(10, 2, 0, 5);
        issue(1, 1, 2, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        issue_wait(4, 1, 1, 0);
        chk("aborted_add_reg", int'(result), 0);

        // Retired count wraps at 2^CNT_W.
        do_reset();
        for (int k = 1; k <= CMOD; k++) begin
            issue_wait(0, 0, 0, 0);
            if (k == CMOD - 1) chk("count_max", int'(retired_count), CMOD - 1);
        end
        chk("count_wrap", int'(retired_count), 0);
        chk("count_model", int'(retired_count), mcnt);

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
